// File: rtl/fp_pkg.sv
// Shared constants and types for FP unit schedulers: rounding modes, adder latency,
// and the default-configuration result record.
package fp_pkg;

    localparam logic [2:0] RND_RNE = 3'd0;
    localparam logic [2:0] RND_RTZ = 3'd1;
    localparam logic [2:0] RND_RDN = 3'd2;
    localparam logic [2:0] RND_RUP = 3'd3;
    localparam logic [2:0] RND_RMM = 3'd4;

    localparam int FP_ADD_LAT = 2;

    localparam int FP_RV   = 64;
    localparam int FP_TAGW = 6;
    localparam int FP_SRCW = 2;

    typedef struct packed {
        logic [FP_RV-1:0]   data;
        logic               exception;
        logic [FP_TAGW-1:0] tag;
        logic [FP_SRCW-1:0] src;
    } fp_res_t;

endpackage

// File: rtl/fp_add_sched_rr_arb.sv
// Round-robin arbiter: first set request at or after ptr (wrapping) wins when enabled.
module rr_arb #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic found;
        int   j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!found && enable && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fp_add_sched.sv
// Shares one fixed-latency fp_add_sub between NREQ requesters; a shadow pipeline tracks
// tag/source beside the adder and results queue in a credit-protected FIFO.
module fp_add_sched
    import fp_pkg::*;
#(
    parameter int RV    = 64,
    parameter int NREQ  = 4,
    parameter int TAGW  = 6,
    parameter int LAT   = FP_ADD_LAT,
    parameter int DEPTH = 4,
    localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_sz,
    input  logic [NREQ-1:0]      req_sub,
    input  logic [3*NREQ-1:0]    req_rnd,
    input  logic [RV*NREQ-1:0]   req_in_1,
    input  logic [RV*NREQ-1:0]   req_in_2,
    input  logic [TAGW*NREQ-1:0] req_tag,
    output logic [NREQ-1:0]      ack,
    input  logic                 flush,
    output logic                 add_start,
    output logic                 add_sz,
    output logic                 add_sub,
    output logic [2:0]           add_rnd,
    output logic [RV-1:0]        add_in_1,
    output logic [RV-1:0]        add_in_2,
    input  logic                 add_valid,
    input  logic                 add_exception,
    input  logic [RV-1:0]        add_res,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [RV-1:0]        res_data,
    output logic                 res_exception,
    output logic [TAGW-1:0]      res_tag,
    output logic [SRCW-1:0]      res_src,
    output logic                 busy
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int SUMW = $clog2(DEPTH + LAT + 1);

    typedef struct packed {
        logic [RV-1:0]   data;
        logic            exception;
        logic [TAGW-1:0] tag;
        logic [SRCW-1:0] src;
    } res_t;

    logic [SRCW-1:0] rr_q, rr_d;
    logic [LAT-1:0]  shd_v_q, shd_v_d;
    logic [TAGW-1:0] shd_tag_q [LAT];
    logic [TAGW-1:0] shd_tag_d [LAT];
    logic [SRCW-1:0] shd_src_q [LAT];
    logic [SRCW-1:0] shd_src_d [LAT];
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    res_t            mem_q [DEPTH];

    logic [SUMW-1:0] inflight;
    logic [SUMW-1:0] used;
    logic            credit_ok;
    logic            arb_en;
    logic [NREQ-1:0] gnt;
    logic [SRCW-1:0] gidx;
    logic            grant;
    logic [TAGW-1:0] grant_tag;
    logic            push;
    logic            pop;
    res_t            head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits count only registered occupancy, so a same-cycle pop never frees a slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + SUMW'(shd_v_q[i]);
        end
        used      = SUMW'(cnt_q) + inflight;
        credit_ok = used < SUMW'(DEPTH);
        arb_en    = credit_ok & ~flush & reset_n;
    end

    rr_arb #(.N(NREQ)) u_arb (
        .req    (req),
        .ptr    (rr_q),
        .enable (arb_en),
        .gnt    (gnt),
        .idx    (gidx)
    );

    always_comb begin
        grant     = |gnt;
        ack       = gnt;
        add_start = grant;
        add_sz    = req_sz[gidx];
        add_sub   = req_sub[gidx];
        add_rnd   = req_rnd[gidx*3 +: 3];
        add_in_1  = req_in_1[gidx*RV +: RV];
        add_in_2  = req_in_2[gidx*RV +: RV];
        grant_tag = req_tag[gidx*TAGW +: TAGW];
    end

    always_comb begin
        rr_d = rr_q;
        if (grant) begin
            rr_d = (gidx == SRCW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end

        shd_v_d[0]   = grant;
        shd_tag_d[0] = grant_tag;
        shd_src_d[0] = gidx;
        for (int i = 1; i < LAT; i++) begin
            shd_v_d[i]   = shd_v_q[i-1];
            shd_tag_d[i] = shd_tag_q[i-1];
            shd_src_d[i] = shd_src_q[i-1];
        end
        if (flush) begin
            shd_v_d = '0;
        end
    end

    // The shadow valid, not add_valid, decides what enters the FIFO.
    always_comb begin
        push  = shd_v_q[LAT-1] & ~flush;
        pop   = res_valid & res_ready;
        cnt_d = cnt_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        if (flush) begin
            cnt_d = '0;
            rd_d  = wr_q;
        end else begin
            if (push) wr_d = ptr_inc(wr_q);
            if (pop)  rd_d = ptr_inc(rd_q);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q    <= '0;
            shd_v_q <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            rr_q    <= rr_d;
            shd_v_q <= shd_v_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        shd_tag_q <= shd_tag_d;
        shd_src_q <= shd_src_d;
        if (push) begin
            mem_q[wr_q] <= '{data: add_res, exception: add_exception,
                             tag: shd_tag_q[LAT-1], src: shd_src_q[LAT-1]};
        end
    end

    always_comb begin
        head          = mem_q[rd_q];
        res_valid     = (cnt_q != '0);
        res_data      = head.data;
        res_exception = head.exception;
        res_tag       = head.tag;
        res_src       = head.src;
        busy          = (|shd_v_q) | (cnt_q != '0);
    end

`ifndef SYNTHESIS
    a_add_valid: assert property (@(posedge clk) disable iff (!reset_n)
        shd_v_q[LAT-1] |-> add_valid);
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        (push && cnt_q == CNTW'(DEPTH)) |-> pop);
`endif

endmodule

// File: tb/tb_fp_add_sched.sv
// Directed bench for fp_add_sched with a behavioural two-stage adder and a result scoreboard.
module tb_fp_add_sched;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [3:0]    req;
    logic [3:0]    req_sz;
    logic [3:0]    req_sub;
    logic [11:0]   req_rnd;
    logic [255:0]  req_in_1;
    logic [255:0]  req_in_2;
    logic [23:0]   req_tag;
    logic [3:0]    ack;
    logic          flush;
    logic          add_start, add_sz, add_sub;
    logic [2:0]    add_rnd;
    logic [63:0]   add_in_1, add_in_2;
    logic          add_valid, add_exception;
    logic [63:0]   add_res;
    logic          res_valid, res_ready;
    logic [63:0]   res_data;
    logic          res_exception;
    logic [5:0]    res_tag;
    logic [1:0]    res_src;
    logic          busy;

    logic [63:0]   op1 [4];
    logic [63:0]   op2 [4];
    logic [5:0]    tg  [4];
    logic [2:0]    rnd [4];
    logic [63:0]   expd[4];
    logic          expx[4];

    int checks = 0;
    int failures = 0;
    int nres = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_in_1 = '0;
        req_in_2 = '0;
        req_tag  = '0;
        req_rnd  = '0;
        for (int i = 0; i < 4; i++) begin
            req_in_1[i*64 +: 64] = op1[i];
            req_in_2[i*64 +: 64] = op2[i];
            req_tag[i*6 +: 6]    = tg[i];
            req_rnd[i*3 +: 3]    = rnd[i];
        end
    end

    fp_add_sched dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_sz(req_sz), .req_sub(req_sub),
        .req_rnd(req_rnd), .req_in_1(req_in_1), .req_in_2(req_in_2), .req_tag(req_tag),
        .ack(ack), .flush(flush), .add_start(add_start), .add_sz(add_sz), .add_sub(add_sub),
        .add_rnd(add_rnd), .add_in_1(add_in_1), .add_in_2(add_in_2), .add_valid(add_valid),
        .add_exception(add_exception), .add_res(add_res), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_exception(res_exception),
        .res_tag(res_tag), .res_src(res_src), .busy(busy)
    );

    // Behavioural double-precision adder, start-to-valid latency 2, not reset.
    function automatic logic [64:0] fadd(input logic [63:0] a, input logic [63:0] b, input logic sub);
        logic [63:0] bb;
        bb = sub ? (b ^ 64'h8000_0000_0000_0000) : b;
        if (a[62:52] == 11'h7FF && a[51:0] == 52'd0 && bb[62:52] == 11'h7FF &&
            bb[51:0] == 52'd0 && a[63] != bb[63])
            return {1'b1, 64'h7FF8_0000_0000_0000};
        return {1'b0, $realtobits($bitstoreal(a) + $bitstoreal(bb))};
    endfunction

    logic        s1_v = 1'b0, s2_v = 1'b0;
    logic [64:0] s1_r = '0, s2_r = '0;
    always @(posedge clk) begin
        s1_v <= add_start;
        s1_r <= fadd(add_in_1, add_in_2, add_sub);
        s2_v <= s1_v;
        s2_r <= s1_r;
    end
    assign add_valid     = s2_v;
    assign add_exception = s2_r[64];
    assign add_res       = s2_r[63:0];

    typedef struct {
        logic [5:0]  tag;
        logic [1:0]  src;
        logic [63:0] data;
        logic        exc;
    } exp_t;
    exp_t q[$];

    typedef struct {
        int          src;
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [5:0]  tag;
        logic [63:0] exp_d;
        logic        exp_x;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic sample();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            if (ack[i]) q.push_back('{tg[i], 2'(i), expd[i], expx[i]});
        if (res_valid && res_ready) begin
            nres++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got result tag %h, required no result", res_tag);
            end else begin
                e = q.pop_front();
                chk("sb_tag", 64'(res_tag), 64'(e.tag));
                chk("sb_src", 64'(res_src), 64'(e.src));
                chk("sb_data", res_data, e.data);
                chk("sb_exc", 64'(res_exception), 64'(e.exc));
            end
        end
        if (flush) q.delete();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            sample();
            if (!busy) done = 1'b1;
            adv();
        end
        chk("drain_idle", 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int rr_exp;
        int nack;
        int nres0;
        bit acked;

        vt[0] = '{1, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 6'h05, 64'h4008_0000_0000_0000, 1'b0};
        vt[1] = '{2, 64'h4010_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, 6'h11, 64'h4008_0000_0000_0000, 1'b0};
        vt[2] = '{3, 64'h3FE0_0000_0000_0000, 64'h3FD0_0000_0000_0000, 1'b0, 6'h3F, 64'h3FE8_0000_0000_0000, 1'b0};
        vt[3] = '{0, 64'h7FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000, 1'b1, 6'h00, 64'h7FF8_0000_0000_0000, 1'b1};
        vt[4] = '{1, 64'h4000_0000_0000_0000, 64'hC000_0000_0000_0000, 1'b0, 6'h20, 64'h0000_0000_0000_0000, 1'b0};
        vt[5] = '{0, 64'hBFF8_0000_0000_0000, 64'h3FE0_0000_0000_0000, 1'b1, 6'h09, 64'hC000_0000_0000_0000, 1'b0};

        for (int i = 0; i < 4; i++) begin
            op1[i] = '0; op2[i] = '0; tg[i] = '0; rnd[i] = '0; expd[i] = '0; expx[i] = 1'b0;
        end
        req = '0; req_sz = 4'hF; req_sub = '0; flush = 1'b0; res_ready = 1'b1;

        // Reset: outputs idle even with every request raised.
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 req = 4'hF;
        @(negedge clk);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_start", 64'(add_start), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        adv();
        req = '0;
        reset_n = 1'b1;
        adv();

        // Single requests: same-cycle ack and mux, result LAT+1 cycles later.
        for (int v = 0; v < 6; v++) begin
            op1[vt[v].src]  = vt[v].a;
            op2[vt[v].src]  = vt[v].b;
            tg[vt[v].src]   = vt[v].tag;
            rnd[vt[v].src]  = 3'(v % 5);
            expd[vt[v].src] = vt[v].exp_d;
            expx[vt[v].src] = vt[v].exp_x;
            req_sub = '0;
            req_sub[vt[v].src] = vt[v].sub;
            req = '0;
            req[vt[v].src] = 1'b1;
            sample();
            chk("t1_ack", 64'(ack), 64'd1 << vt[v].src);
            chk("t1_start", 64'(add_start), 64'd1);
            chk("t1_in1", add_in_1, vt[v].a);
            chk("t1_in2", add_in_2, vt[v].b);
            chk("t1_sub", 64'(add_sub), 64'(vt[v].sub));
            chk("t1_rnd", 64'(add_rnd), 64'(v % 5));
            chk("t1_sz", 64'(add_sz), 64'd1);
            adv();
            req = '0;
            for (int k = 1; k <= 3; k++) begin
                sample();
                if (k < 3) begin
                    chk("t1_early_valid", 64'(res_valid), 64'd0);
                end else begin
                    chk("t1_valid", 64'(res_valid), 64'd1);
                    chk("t1_data", res_data, vt[v].exp_d);
                    chk("t1_exc", 64'(res_exception), 64'(vt[v].exp_x));
                    chk("t1_tag", 64'(res_tag), 64'(vt[v].tag));
                    chk("t1_src", 64'(res_src), 64'(vt[v].src));
                end
                adv();
            end
            sample();
            chk("t1_busy_after", 64'(busy), 64'd0);
            adv();
        end

        // All four held: strict round robin from the pointer left by the last grant (src 0).
        req_sub = '0;
        for (int i = 0; i < 4; i++) begin
            op1[i] = 64'h3FF0_0000_0000_0000; op2[i] = 64'h4000_0000_0000_0000;
            expd[i] = 64'h4008_0000_0000_0000; expx[i] = 1'b0; tg[i] = 6'(16 + i);
        end
        rr_exp = 1;
        req = 4'hF;
        for (int k = 0; k < 8; k++) begin
            sample();
            chk("t2_rr_ack", 64'(ack), 64'd1 << rr_exp);
            rr_exp = (rr_exp + 1) % 4;
            adv();
        end
        req = '0;
        drain();

        // Stalled consumer: exactly DEPTH ops issue, then drain in order and resume.
        res_ready = 1'b0;
        tg[0] = 6'h01;
        req = 4'b0001;
        nack = 0;
        for (int k = 0; k < 10; k++) begin
            sample();
            acked = ack[0];
            if (acked) nack++;
            adv();
            if (acked) tg[0] = tg[0] + 1'b1;
        end
        chk("t3_acks_stalled", 64'(nack), 64'd4);
        chk("t3_full_valid", 64'(res_valid), 64'd1);
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sample();
            acked = ack[0];
            if (acked) nack++;
            adv();
            if (acked) tg[0] = tg[0] + 1'b1;
        end
        req = '0;
        drain();

        // Full FIFO popping: no same-cycle credit, then order holds across the pointer wrap.
        res_ready = 1'b0;
        tg[0] = 6'h30;
        req = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            sample();
            acked = ack[0];
            adv();
            if (acked) tg[0] = tg[0] + 1'b1;
        end
        res_ready = 1'b1;
        sample();
        chk("t5_full_pop_no_credit", 64'(ack), 64'd0);
        chk("t5_full_valid", 64'(res_valid), 64'd1);
        adv();
        for (int k = 0; k < 12; k++) begin
            sample();
            if (k == 0) chk("t5_credit_next", 64'(ack), 64'd1);
            acked = ack[0];
            adv();
            if (acked) tg[0] = tg[0] + 1'b1;
        end
        req = '0;
        drain();

        // Flush on the cycle the first op would push; a grant follows immediately.
        nres0 = nres;
        tg[0] = 6'h21; tg[1] = 6'h22; tg[2] = 6'h23;
        req = 4'b0001;
        sample(); adv();
        req = 4'b0010;
        sample(); adv();
        req = 4'b0100;
        flush = 1'b1;
        sample();
        chk("t4_flush_ack", 64'(ack), 64'd0);
        chk("t4_flush_start", 64'(add_start), 64'd0);
        adv();
        flush = 1'b0;
        sample();
        chk("t4_busy_after", 64'(busy), 64'd0);
        chk("t4_valid_after", 64'(res_valid), 64'd0);
        chk("t4_regrant", 64'(ack), 64'b0100);
        adv();
        req = '0;
        drain();
        chk("t4_results", 64'(nres - nres0), 64'd1);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 4; i++) tg[i] = 6'(40 + i);
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            sample(); adv();
        end
        #2 reset_n = 1'b0;
        #1;
        chk("t6_ack", 64'(ack), 64'd0);
        chk("t6_start", 64'(add_start), 64'd0);
        chk("t6_valid", 64'(res_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        q.delete();
        req = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        nres0 = nres;
        tg[1] = 6'h3A; tg[3] = 6'h3B;
        req = 4'b1010;
        sample();
        chk("t6_rr_reset", 64'(ack), 64'b0010);
        adv();
        sample();
        chk("t6_rr_next", 64'(ack), 64'b1000);
        adv();
        req = '0;
        drain();
        chk("t6_results", 64'(nres - nres0), 64'd2);
        chk("sb_outstanding", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
